// File: rtl/sub_sub_add_pipe_if.sv
// Streaming bus for sub_sub_add_pipe: input beat (num1/num2/num3) with
// valid/ready, output beat (result/ovf) with valid/ready, plus overflow
// status, sticky clear and the accepted-beat counter.
// master = the side that produces operands and consumes results.
// slave  = the arithmetic unit.
interface sub_sub_add_pipe_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = 4,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                          in_valid;
    logic                          in_ready;
    logic [LANES*DATA_WIDTH-1:0]   num1;
    logic [LANES*DATA_WIDTH-1:0]   num2;
    logic [LANES*DATA_WIDTH-1:0]   num3;
    logic                          out_valid;
    logic                          out_ready;
    logic [LANES*DATA_WIDTH-1:0]   result;
    logic [LANES-1:0]              ovf;
    logic [LANES-1:0]              ovf_sticky;
    logic                          ovf_clr;
    logic [CNT_WIDTH-1:0]          beat_cnt;

    modport master (
        output in_valid, num1, num2, num3, out_ready, ovf_clr,
        input  in_ready, out_valid, result, ovf, ovf_sticky, beat_cnt
    );

    modport slave (
        input  in_valid, num1, num2, num3, out_ready, ovf_clr,
        output in_ready, out_valid, result, ovf, ovf_sticky, beat_cnt
    );
endinterface

// File: rtl/sub_sub_add_pipe.sv
// sub_sub_add_pipe: per-lane result = num3 - num1 - num2, two-stage
// valid/ready pipeline with per-lane overflow flag, sticky overflow status
// and a wrapping count of accepted output beats.
// Optional feature macro: SUB_SUB_ADD_SATURATE_EN -- when defined, an
// overflowing lane clamps to the signed min/max instead of wrapping.
module sub_sub_add_pipe #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    sub_sub_add_pipe_if.slave bus
);

    // Two guard bits hold any -a-b+c of DATA_WIDTH-bit signed operands.
    localparam int unsigned EXT_W = DATA_WIDTH + 2;
    localparam int unsigned VEC_W = LANES * DATA_WIDTH;
    localparam int unsigned P_W   = LANES * EXT_W;

    // Stage 1: partial sum and the addend, captured on input transfer
    logic                 v1_q, v1_d;
    logic [P_W-1:0]       p_q, p_d;
    logic [VEC_W-1:0]     c_q, c_d;

    // Stage 2: final lane results and overflow flags
    logic                 v2_q, v2_d;
    logic [VEC_W-1:0]     result_q, result_d;
    logic [LANES-1:0]     ovf_q, ovf_d;

    // Status
    logic [LANES-1:0]     sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Handshake / datapath combinational terms
    logic                 s2_load_c;
    logic                 s1_load_c;
    logic                 in_xfer_c;
    logic                 out_xfer_c;
    logic [P_W-1:0]       p_calc_c;
    logic [VEC_W-1:0]     res_calc_c;
    logic [LANES-1:0]     ovf_calc_c;
    logic [EXT_W-1:0]     r_c [LANES];

    function automatic logic [EXT_W-1:0] sext(input logic [DATA_WIDTH-1:0] x);
        return {{(EXT_W - DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
    endfunction

    // Stall rule: a stage loads when it is empty or its successor advances.
    always_comb begin
        s2_load_c  = ~v2_q | bus.out_ready;
        s1_load_c  = ~v1_q | s2_load_c;
        in_xfer_c  = bus.in_valid & s1_load_c;
        out_xfer_c = v2_q & bus.out_ready;
    end

    // Stage 1 arithmetic: p = -num1 - num2 in the widened domain.
    always_comb begin
        p_calc_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            p_calc_c[i*EXT_W +: EXT_W] = -sext(bus.num1[i*DATA_WIDTH +: DATA_WIDTH])
                                         - sext(bus.num2[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Stage 2 arithmetic: r = p + num3, range check, then wrap or clamp.
    always_comb begin
        r_c        = '{default: '0};
        res_calc_c = '0;
        ovf_calc_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            r_c[i] = p_q[i*EXT_W +: EXT_W] + sext(c_q[i*DATA_WIDTH +: DATA_WIDTH]);
            // In range exactly when the guard bits and the result sign agree.
            ovf_calc_c[i] = ~((&r_c[i][EXT_W-1:DATA_WIDTH-1]) |
                              ~(|r_c[i][EXT_W-1:DATA_WIDTH-1]));
`ifdef SUB_SUB_ADD_SATURATE_EN
            if (ovf_calc_c[i]) begin
                res_calc_c[i*DATA_WIDTH +: DATA_WIDTH] = r_c[i][EXT_W-1]
                    ? {1'b1, {(DATA_WIDTH - 1){1'b0}}}
                    : {1'b0, {(DATA_WIDTH - 1){1'b1}}};
            end else begin
                res_calc_c[i*DATA_WIDTH +: DATA_WIDTH] = r_c[i][DATA_WIDTH-1:0];
            end
`else
            res_calc_c[i*DATA_WIDTH +: DATA_WIDTH] = r_c[i][DATA_WIDTH-1:0];
`endif
        end
    end

    // Next-state: stage advance, data capture, sticky and counter update.
    always_comb begin
        v1_d     = v1_q;
        p_d      = p_q;
        c_d      = c_q;
        v2_d     = v2_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;

        if (s1_load_c) begin
            v1_d = bus.in_valid;
        end
        if (in_xfer_c) begin
            p_d = p_calc_c;
            c_d = bus.num3;
        end

        if (s2_load_c) begin
            v2_d = v1_q;
        end
        // Only real beats overwrite the output registers, so result/ovf
        // keep their last values while out_valid is low.
        if (s2_load_c && v1_q) begin
            result_d = res_calc_c;
            ovf_d    = ovf_calc_c;
        end

        // Clear first, then set, so a same-cycle set survives the clear.
        if (bus.ovf_clr) begin
            sticky_d = '0;
        end
        if (out_xfer_c) begin
            sticky_d = sticky_d | ovf_q;
            cnt_d    = cnt_q + CNT_WIDTH'(1);
        end
    end

    // State registers with asynchronous flush of both stages and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            p_q      <= '0;
            c_q      <= '0;
            v2_q     <= 1'b0;
            result_q <= '0;
            ovf_q    <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            v1_q     <= v1_d;
            p_q      <= p_d;
            c_q      <= c_d;
            v2_q     <= v2_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    // Output drive
    assign bus.in_ready   = s1_load_c;
    assign bus.out_valid  = v2_q;
    assign bus.result     = result_q;
    assign bus.ovf        = ovf_q;
    assign bus.ovf_sticky = sticky_q;
    assign bus.beat_cnt   = cnt_q;

endmodule

// File: tb/tb_sub_sub_add_pipe.sv
// Testbench for sub_sub_add_pipe: directed scenarios plus random traffic,
// checked against a queue-based behavioural model. A second instance with a
// 4-bit counter shares all inputs to exercise counter wrap.
module tb_sub_sub_add_pipe;

    localparam int unsigned DW = 8;
    localparam int unsigned LN = 4;
    localparam int unsigned VW = DW * LN;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sub_sub_add_pipe_if #(.DATA_WIDTH(DW), .LANES(LN), .CNT_WIDTH(16)) bus ();
    sub_sub_add_pipe_if #(.DATA_WIDTH(DW), .LANES(LN), .CNT_WIDTH(4))  bus_s ();

    assign bus_s.in_valid  = bus.in_valid;
    assign bus_s.num1      = bus.num1;
    assign bus_s.num2      = bus.num2;
    assign bus_s.num3      = bus.num3;
    assign bus_s.out_ready = bus.out_ready;
    assign bus_s.ovf_clr   = bus.ovf_clr;

    sub_sub_add_pipe #(.DATA_WIDTH(DW), .LANES(LN), .CNT_WIDTH(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    sub_sub_add_pipe #(.DATA_WIDTH(DW), .LANES(LN), .CNT_WIDTH(4)) u_dut_w4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    // Reference model: beats in flight, in acceptance order.
    typedef struct {
        logic [VW-1:0] res;
        logic [LN-1:0] ovf;
        int            acc;
    } beat_t;

    beat_t         q[$];
    int            cyc;
    logic [LN-1:0] m_sticky;
    int unsigned   m_cnt;
    int            n_chk;
    int            n_fail;

`ifdef SUB_SUB_ADD_SATURATE_EN
    localparam logic [DW-1:0] OVF_LANE1_EXP = 8'h80;
`else
    localparam logic [DW-1:0] OVF_LANE1_EXP = 8'hD4;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Plain integer arithmetic per lane: num3 - num1 - num2, then range rule.
    function automatic beat_t model_beat(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                         input logic [VW-1:0] c);
        beat_t e;
        e.res = '0;
        e.ovf = '0;
        e.acc = 0;
        for (int i = 0; i < LN; i++) begin
            logic signed [DW-1:0] sa, sb, sc;
            int r;
            sa = a[i*DW +: DW];
            sb = b[i*DW +: DW];
            sc = c[i*DW +: DW];
            r  = int'(sc) - int'(sa) - int'(sb);
            if (r > 127 || r < -128) e.ovf[i] = 1'b1;
`ifdef SUB_SUB_ADD_SATURATE_EN
            if (r > 127) r = 127;
            else if (r < -128) r = -128;
`endif
            e.res[i*DW +: DW] = DW'(r);
        end
        return e;
    endfunction

    function automatic logic exp_out_valid();
        return (q.size() > 0) && (cyc >= q[0].acc + 1);
    endfunction

    // Compare every output against the model (called just after a falling edge).
    task automatic verify();
        logic ov;
        ov = exp_out_valid();
        check("out_valid", bus.out_valid, ov);
        check("out_valid_w4", bus_s.out_valid, ov);
        if (ov) begin
            check("result", bus.result, q[0].res);
            check("ovf", bus.ovf, q[0].ovf);
        end
        check("ovf_sticky", bus.ovf_sticky, m_sticky);
        check("beat_cnt", bus.beat_cnt, 16'(m_cnt));
        check("beat_cnt_w4", bus_s.beat_cnt, 4'(m_cnt));
    endtask

    // One clock cycle: drive inputs, check in_ready, advance model and DUT.
    task automatic step(input logic iv, input logic [VW-1:0] a, input logic [VW-1:0] b,
                        input logic [VW-1:0] c, input logic ordy, input logic clr,
                        output logic took);
        beat_t e;
        logic  exp_ir;
        logic  oxfer;
        bus.in_valid  = iv;
        bus.num1      = a;
        bus.num2      = b;
        bus.num3      = c;
        bus.out_ready = ordy;
        bus.ovf_clr   = clr;
        #1;
        exp_ir = !((q.size() == 2) && !ordy);
        check("in_ready", bus.in_ready, exp_ir);
        oxfer = exp_out_valid() && ordy;
        took  = iv && exp_ir;
        if (clr) m_sticky = '0;
        if (oxfer) begin
            m_sticky = m_sticky | q[0].ovf;
            m_cnt++;
            void'(q.pop_front());
        end
        if (took) begin
            e     = model_beat(a, b, c);
            e.acc = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        verify();
    endtask

    // Asynchronous reset pulse; checks flush takes effect without a clock.
    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.num1      = '0;
        bus.num2      = '0;
        bus.num3      = '0;
        bus.out_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        rst_n         = 1'b0;
        #1;
        q.delete();
        m_sticky = '0;
        m_cnt    = 0;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_beat_cnt", bus.beat_cnt, 16'd0);
        check("rst_ovf_sticky", bus.ovf_sticky, 4'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_ovf", bus.ovf, 4'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic          took;
        logic [VW-1:0] z;
        logic [VW-1:0] v;
        int            k;
        int            t;
        z        = '0;
        cyc      = 0;
        n_chk    = 0;
        n_fail   = 0;
        m_sticky = '0;
        m_cnt    = 0;
        rst_n    = 1'b1;
        bus.in_valid  = 1'b0;
        bus.num1      = '0;
        bus.num2      = '0;
        bus.num3      = '0;
        bus.out_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        #2;
        do_reset();

        // Basic: lane0 20 - 3 - 5 = 12, two-cycle latency.
        step(1'b1, 32'h3, 32'h5, 32'd20, 1'b1, 1'b0, took);
        check("basic_not_yet", bus.out_valid, 1'b0);
        step(1'b0, z, z, z, 1'b1, 1'b0, took);
        check("basic_valid", bus.out_valid, 1'b1);
        check("basic_res0", bus.result[7:0], 8'h0C);
        check("basic_ovf", bus.ovf, 4'd0);
        step(1'b0, z, z, z, 1'b1, 1'b0, took);
        check("basic_cnt", bus.beat_cnt, 16'd1);

        // Overflow: lane1 -100 - 100 - 100 = -300.
        step(1'b1, 32'h0000_6400, 32'h0000_6400, 32'h0000_9C00, 1'b1, 1'b0, took);
        step(1'b0, z, z, z, 1'b1, 1'b0, took);
        check("ovf_res1", bus.result[15:8], OVF_LANE1_EXP);
        check("ovf_flag", bus.ovf, 4'b0010);
        step(1'b0, z, z, z, 1'b1, 1'b0, took);
        check("ovf_sticky1", bus.ovf_sticky, 4'b0010);

        // Backpressure: five beats 1..5, downstream stalled for cycles 0-5.
        do_reset();
        k = 1;
        t = 0;
        while (k <= 5 && t < 60) begin
            v = {4{8'(k)}};
            step(1'b1, v, z, z, (t >= 6), 1'b0, took);
            if (t == 2) check("bp_in_ready_low", bus.in_ready, 1'b0);
            if (took) k++;
            t++;
        end
        if (k <= 5) check("bp_accept_timeout", 32'(k), 32'd6);
        for (int j = 0; j < 4; j++) step(1'b0, z, z, z, 1'b1, 1'b0, took);
        check("bp_cnt", bus.beat_cnt, 16'd5);
        check("bp_drained", bus.out_valid, 1'b0);

        // Sticky clear: lane0 overflow sets first, then lane2 set collides with clear.
        step(1'b1, 32'h64, 32'h64, 32'h9C, 1'b1, 1'b0, took);
        step(1'b1, 32'h0064_0000, 32'h0064_0000, 32'h009C_0000, 1'b1, 1'b0, took);
        step(1'b0, z, z, z, 1'b1, 1'b0, took);
        check("sc_lane0", bus.ovf_sticky, 4'b0001);
        check("sc_lane2_pending", bus.ovf, 4'b0100);
        step(1'b0, z, z, z, 1'b1, 1'b1, took);
        check("sc_set_wins", bus.ovf_sticky, 4'b0100);
        step(1'b0, z, z, z, 1'b1, 1'b1, took);
        check("sc_cleared", bus.ovf_sticky, 4'b0000);

        // Reset mid-operation with both stages full and status non-zero.
        step(1'b1, 32'h6400_0000, 32'h6400_0000, 32'h9C00_0000, 1'b1, 1'b0, took);
        step(1'b0, z, z, z, 1'b1, 1'b0, took);
        step(1'b0, z, z, z, 1'b1, 1'b0, took);
        check("mr_sticky_pre", bus.ovf_sticky, 4'b1000);
        step(1'b1, 32'h0101_0101, z, z, 1'b0, 1'b0, took);
        step(1'b1, 32'h0202_0202, z, z, 1'b0, 1'b0, took);
        check("mr_full", bus.in_ready, 1'b0);
        do_reset();
        for (int j = 0; j < 4; j++) step(1'b0, z, z, z, 1'b1, 1'b0, took);
        check("mr_no_stale", bus.beat_cnt, 16'd0);

        // Counter wrap: 17 transfers on the 4-bit counter instance.
        for (int j = 0; j < 17; j++) begin
            logic [VW-1:0] ra, rb, rc;
            ra = $urandom;
            rb = $urandom;
            rc = $urandom;
            step(1'b1, ra, rb, rc, 1'b1, 1'b0, took);
        end
        for (int j = 0; j < 3; j++) step(1'b0, z, z, z, 1'b1, 1'b0, took);
        check("wrap_w4", bus_s.beat_cnt, 4'd1);
        check("wrap_w16", bus.beat_cnt, 16'd17);

        // Random traffic with random stalls and clears.
        for (int j = 0; j < 400; j++) begin
            logic [VW-1:0] ra, rb, rc;
            ra = $urandom;
            rb = $urandom;
            rc = $urandom;
            step(($urandom_range(0, 9) < 7), ra, rb, rc, ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) == 0), took);
        end
        for (int j = 0; j < 4; j++) step(1'b0, z, z, z, 1'b1, 1'b0, took);
        check("rand_drained", bus.out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sub_sub_add_pipe.md
Name: sub_sub_add_pipe

Overview:
- Multi-lane, pipelined successor of the pseudo-softmax combinational negate-negate-add unit.
- Per lane, computes result = num3 - num1 - num2 in signed two's complement.
- Adds valid/ready streaming with backpressure, per-lane overflow detection, sticky overflow status and an accepted-beat counter.
- Sits between the log-domain max/subtract stage and the exponent/normalise stage of the softmax datapath.

Parameters:
- DATA_WIDTH, 8: per-lane operand and result width, signed two's complement.
- LANES, 4: number of independent parallel lanes.
- CNT_WIDTH, 16: width of the accepted-output-beat counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept an input beat.
- num1  in  LANES*DATA_WIDTH  subtrahend A; lane i is at [i*DATA_WIDTH +: DATA_WIDTH].
- num2  in  LANES*DATA_WIDTH  subtrahend B, same packing.
- num3  in  LANES*DATA_WIDTH  addend, same packing.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- result  out  LANES*DATA_WIDTH  per-lane result, same packing.
- ovf  out  LANES  per-lane overflow flag, aligned with result.
- ovf_sticky  out  LANES  per-lane sticky overflow status.
- ovf_clr  in  1  synchronous clear of ovf_sticky.
- beat_cnt  out  CNT_WIDTH  count of accepted output beats.

Behaviour:
- Reset (async assert, sync release): stage valids, result, ovf, ovf_sticky and beat_cnt all go to 0. in_ready is 1 after reset because both stages are empty.
- Input handshake: a beat transfers when in_valid and in_ready are both 1. Output handshake: a beat transfers when out_valid and out_ready are both 1. Inputs are sampled only on input transfer.
- Stage 1 (S1): per lane, p = -num1 - num2, sign-extended to DATA_WIDTH+2 bits. Stored with valid v1.
- Stage 2 (S2): per lane, r = p + sext(num3) in DATA_WIDTH+2 bits. Stored as result/ovf with valid v2, which drives out_valid.
- Latency is 2 cycles from input transfer to out_valid with no stall. Throughput is 1 beat per cycle when out_ready is held at 1.
- Stall rule: S2 loads when (!v2 | out_ready). S1 loads when (!v1 | S2 loads). in_ready equals the S1 load condition. Bubbles collapse, so no bubble is held while a downstream stage is empty.
- Registered data never changes while its valid=1 and that stage is not advancing. No beat is lost or duplicated, and order is preserved.
- Overflow: ovf[i] = 1 when r is outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. It is computed regardless of the feature macro.
- Default result: result lane = r[DATA_WIDTH-1:0]. This is identical to mod 2^DATA_WIDTH wrap of -num1 + -num2 + num3.
- ovf_sticky[i] sets on an output transfer with ovf[i]=1. ovf_clr clears all bits. When set and clear happen in the same cycle, set wins for the affected lanes.
- beat_cnt increments by 1 on each output transfer and wraps from 2^CNT_WIDTH-1 to 0. It is not cleared by ovf_clr.
- When out_valid=0, result and ovf hold their last values. Consumers must qualify them with out_valid.
- Reset asserted mid-stream flushes both stages. In-flight beats are discarded and never appear at the output.

Optional Feature:
- SUB_SUB_ADD_SATURATE_EN defined: a lane with ovf=1 outputs 2^(DATA_WIDTH-1)-1 when r>0, and -2^(DATA_WIDTH-1) when r<0. ovf and ovf_sticky behave the same as without the macro.
- SUB_SUB_ADD_SATURATE_EN undefined: result wraps modulo 2^DATA_WIDTH. No saturation logic is present.

Test Plan:
- All tests use DATA_WIDTH=8 and LANES=4.
- Basic: lane0 num1=3, num2=5, num3=20, out_ready=1, single beat -> out_valid 2 cycles later, lane0 result=0x0C, ovf=0, beat_cnt=1.
- Overflow: lane1 num1=100, num2=100, num3=-100 (0x9C) -> r=-300, ovf[1]=1, ovf_sticky[1]=1 after transfer. Result is 0xD4 without the macro, 0x80 with SUB_SUB_ADD_SATURATE_EN.
- Backpressure: in_valid=1 for 5 consecutive beats with values 1..5, out_ready=0 for cycles 0-5 -> in_ready=0 once 2 beats are held. Releasing out_ready delivers 5 beats in order with no loss or duplicates, and beat_cnt=5.
- Sticky clear: ovf_clr pulsed in the same cycle as an output transfer with ovf[2]=1 -> ovf_sticky[2]=1 and the other sticky bits=0. An ovf_clr pulse the next cycle with no overflow -> all sticky bits 0.
- Reset mid-operation: assert rst_n=0 with v1=v2=1 -> out_valid=0, beat_cnt=0 and ovf_sticky=0 immediately (asynchronous). After release, in_ready=1 and no stale beat emerges.
- Counter wrap: with CNT_WIDTH=4, 17 output transfers -> beat_cnt=1.
